// File: rtl/serial_logic_unit.sv
// Bit-serial two-operand logic unit. Latches two operands and an operation
// select, evaluates one bit per clock LSB first through a NAND-only per-bit
// operator, then publishes the full result and its even parity with a
// one-cycle done pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; result/parity hold the last completed op
// S_SHIFT | evaluating one bit per clock into acc, LSB first
// S_DONE  | one-cycle completion pulse; start here begins a new op at once
module serial_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             parity
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_XOR  = 2'b00;
  localparam logic [1:0] M_AND  = 2'b01;
  localparam logic [1:0] M_OR   = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa, sb, acc;
  logic [1:0]       mode_q;
  logic [CW-1:0]    cnt;

  logic             bit_val;
  logic [WIDTH-1:0] acc_next;

  function automatic logic nand2(input logic p, input logic q);
    return ~(p & q);
  endfunction

  // Per-bit operator on the current LSBs, composed strictly of 2-input NANDs.
  always_comb begin
    logic p, q, n_pq, not_p, not_q, and_pq, or_pq, or_n, x_t, xor_pq;
    p       = sa[0];
    q       = sb[0];
    n_pq    = nand2(p, q);
    not_p   = nand2(p, p);
    not_q   = nand2(q, q);
    and_pq  = nand2(n_pq, n_pq);
    or_pq   = nand2(not_p, not_q);
    // OR(NOT p, NOT q): invert each inverted input again before the NAND.
    or_n    = nand2(nand2(not_p, not_p), nand2(not_q, not_q));
    x_t     = nand2(or_n, or_pq);
    xor_pq  = nand2(x_t, x_t);
    bit_val = 1'b0;
    case (mode_q)
      M_XOR:   bit_val = xor_pq;
      M_AND:   bit_val = and_pq;
      M_OR:    bit_val = or_pq;
      default: bit_val = n_pq;
    endcase
  end

  // New bit enters at the MSB; written as shift/or so WIDTH=1 stays legal.
  assign acc_next = (acc >> 1) | (WIDTH'(bit_val) << (WIDTH - 1));

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

  // Sequencer: accept, shift one bit per clock, publish on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      mode_q <= 2'b00;
      cnt    <= '0;
      result <= '0;
      parity <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            mode_q <= mode;
            cnt    <= '0;
            acc    <= '0;
            state  <= S_SHIFT;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          acc <= acc_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            result <= acc_next;
            parity <= ^acc_next;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench for serial_logic_unit (WIDTH=8). Expected results are
// pushed to a scoreboard queue when an operation is started and popped when
// the unit signals done.
module tb_serial_logic_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] a, b;
  logic         busy, done, parity;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  logic [W:0] sb_q[$];

  serial_logic_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .parity(parity)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic [1:0] m);
    logic [W-1:0] r;
    case (m)
      2'b00:   r = x ^ y;
      2'b01:   r = x & y;
      2'b10:   r = x | y;
      default: r = ~(x & y);
    endcase
    return {^r, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive an operation for one accepting edge and record its expectation.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] m);
    a = x; b = y; mode = m; start = 1'b1;
    sb_q.push_back(model(x, y, m));
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done; reports busy cycles seen and whether it timed out.
  task automatic wait_done(output int busy_cyc, output bit timed_out);
    int total = 0;
    busy_cyc = 0;
    while (done !== 1'b1 && total < 40) begin
      if (busy === 1'b1) busy_cyc++;
      tick();
      total++;
    end
    timed_out = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; mode = 2'b00; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, parity} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h parity=%b, want all 0",
               busy, done, result, parity);
    end
    #19 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_xor();
    int bc; bit to; logic [W:0] exp;
    launch(8'hA5, 8'h0F, 2'b00);
    wait_done(bc, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || bc != W) begin
      errors++;
      $display("FAIL xor_latency: busy_cycles=%0d timeout=%0b, want %0d", bc, to, W);
    end
    checks++;
    if ({parity, result} !== exp || exp !== {1'b0, 8'hAA}) begin
      errors++;
      $display("FAIL xor_result: result=%h parity=%b, want %h/%b", result, parity, exp[W-1:0], exp[W]);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL xor_busy_with_done: busy=%b, want 0", busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL xor_done_pulse: done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_modes();
    int bc; bit to; logic [W:0] exp;
    logic [1:0] order[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    foreach (order[i]) begin
      launch(8'h3C, 8'hF1, order[i]);
      wait_done(bc, to);
      exp = sb_q.pop_front();
      checks++;
      if (to || {parity, result} !== exp) begin
        errors++;
        $display("FAIL mode_%0d_result: result=%h parity=%b timeout=%0b, want %h/%b",
                 order[i], result, parity, to, exp[W-1:0], exp[W]);
      end
      repeat (3) tick();
      checks++;
      if ({parity, result} !== exp) begin
        errors++;
        $display("FAIL mode_%0d_hold: result=%h parity=%b, want %h/%b",
                 order[i], result, parity, exp[W-1:0], exp[W]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int bc; bit to; int extra = 0; logic [W:0] exp;
    launch(8'hA5, 8'h0F, 2'b00);
    repeat (2) tick();
    a = 8'hFF; b = 8'hFF; mode = 2'b01; start = 1'b1;
    tick();
    start = 1'b0; a = 8'h00; b = 8'h55; mode = 2'b10;
    wait_done(bc, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || {parity, result} !== exp) begin
      errors++;
      $display("FAIL busy_start_result: result=%h parity=%b timeout=%0b, want %h/%b",
               result, parity, to, exp[W-1:0], exp[W]);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_start_extra: %0d extra busy/done cycles, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit to; logic [W:0] exp;
    launch(8'h3C, 8'hF1, 2'b01);
    wait_done(bc, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || {parity, result} !== exp) begin
      errors++;
      $display("FAIL b2b_first: result=%h parity=%b, want %h/%b", result, parity, exp[W-1:0], exp[W]);
    end
    launch(8'h01, 8'h00, 2'b00);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_idle: busy=%b done=%b after DONE-cycle start, want 1/0", busy, done);
    end
    wait_done(bc, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || bc != W) begin
      errors++;
      $display("FAIL b2b_latency: busy_cycles=%0d timeout=%0b, want %0d", bc, to, W);
    end
    checks++;
    if ({parity, result} !== exp || exp !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL b2b_result: result=%h parity=%b, want %h/%b", result, parity, exp[W-1:0], exp[W]);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int bc; bit to; logic [W:0] exp;
    launch(8'h5A, 8'h33, 2'b10);
    repeat (4) tick();
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    #1;
    checks++;
    if ({busy, done, result, parity} !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b result=%h parity=%b, want all 0",
               busy, done, result, parity);
    end
    #3 rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_discard: busy=%b result=%h after release, want 0/00", busy, result);
    end
    launch(8'hF0, 8'h0F, 2'b00);
    wait_done(bc, to);
    exp = sb_q.pop_front();
    checks++;
    if (to || {parity, result} !== exp || exp !== {1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL post_reset_result: result=%h parity=%b timeout=%0b, want %h/%b",
               result, parity, to, exp[W-1:0], exp[W]);
    end
  endtask

  initial begin
    test_reset();
    test_xor();
    test_modes();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_logic_unit.md
# serial_logic_unit

Parametrised, bit-serial two-operand logic unit: the sequential successor to the single-bit NAND-built XOR gate. It latches two WIDTH-bit operands and an operation select, then evaluates one bit per clock, LSB first, using a NAND-only per-bit operator. It reports completion with a one-cycle `done` pulse, the full result, and its even-parity bit. It sits between a register-level producer and consumer as a small, area-cheap logic coprocessor.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 1..32.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request. Sampled only when `busy`=0.
- `mode` input 2: operation select: 00 XOR, 01 AND, 10 OR, 11 NAND.
- `a` input WIDTH: operand A. Sampled with `start`.
- `b` input WIDTH: operand B. Sampled with `start`.
- `busy` output 1: high while bits are being evaluated.
- `done` output 1: one-cycle pulse when `result`/`parity` update.
- `result` output WIDTH: last completed result. Held between operations.
- `parity` output 1: XOR-reduction of `result`. Updates together with `result`.

## Operation
- States: IDLE, SHIFT, DONE.
- Internal state:
  - Operand shift registers `sa`, `sb` (WIDTH each).
  - Accumulator `acc` (WIDTH).
  - Latched `mode_q` (2).
  - Bit counter `cnt`, width $clog2(WIDTH+1).
- IDLE: `busy`=0, `done`=0. On `start`=1, latch `a`→`sa`, `b`→`sb`, `mode`→`mode_q`; clear `cnt` and `acc`; go to SHIFT.
- SHIFT: `busy`=1. Each edge does all of the following:
  - Compute bit = op(`sa[0]`,`sb[0]`).
  - Shift `acc` right, inserting bit at MSB.
  - Shift `sa`, `sb` right by one.
  - Increment `cnt`.
- SHIFT exit: on the edge where `cnt` = WIDTH-1, the last bit enters `acc`. Also on that edge:
  - Copy the completed value to `result`.
  - Set `parity` = ^completed value.
  - Go to DONE.
- DONE: `busy`=0, `done`=1 for exactly this cycle.
  - `start`=1 here is accepted exactly as in IDLE and goes to SHIFT (back-to-back).
  - Otherwise go to IDLE.
- The per-bit operator is built from 2-input NAND primitives only:
  - NOT x = nand(x,x)
  - AND = NOT(nand)
  - OR = nand(NOT p, NOT q)
  - XOR = AND(OR(NOT p, NOT q), OR(p, q))
- `start` in SHIFT is ignored. No queuing, no error flag.
- Changes to `a`, `b`, `mode` after the accepting edge have no effect on the operation in flight.
- `result`/`parity` never show partial values. They change only on the completing edge.
- WIDTH=1: SHIFT lasts one cycle. `cnt` is 0 on entry, which is already WIDTH-1.

## Timing
- Reset (`rst_n`=0, immediate, no clock needed):
  - State → IDLE.
  - `busy`=0, `done`=0, `result`=0, `parity`=0.
  - All internal registers 0.
- Reset asserted mid-operation discards the operation. Outputs go to reset values at once.
- First `start` is honoured on the first rising edge after `rst_n` deasserts.
- Latency: `start` accepted at edge E.
  - `busy`=1 after edges E..E+WIDTH-1.
  - Completion edge is E+WIDTH: `result`/`parity` valid and `done`=1 for the following cycle.
  - `busy`=0 from edge E+WIDTH.
- Throughput: one operation per WIDTH+1 cycles, with `start` held or re-asserted in the DONE cycle.
- `done` and `busy` are never high together.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle with no clock edge. Outputs read `busy`=0, `done`=0, `result`=0, `parity`=0 immediately.
- XOR, WIDTH=8: `a`=8'hA5, `b`=8'h0F, `mode`=00, `start` pulsed one cycle at edge E.
  - `busy` high for 8 cycles.
  - `done` pulses after edge E+8.
  - `result`=8'hAA, `parity`=0.
- All modes with `a`=8'h3C, `b`=8'hF1:
  - AND → 8'h30, parity 0.
  - OR → 8'hFD, parity 1.
  - NAND → 8'hCF, parity 0.
  - XOR → 8'hCD, parity 1.
  - Each value is held until the next `done`.
- Start while busy: at edge E+3 assert `start` with `a`=8'hFF, `b`=8'hFF, and change `a`/`b`. First result is unchanged (8'hAA case). No extra `done`.
- Back-to-back: hold `start`=1 across the DONE cycle with new operands `a`=8'h01, `b`=8'h00, XOR.
  - Second op enters SHIFT with no IDLE cycle.
  - After 8 more cycles `result`=8'h01, `parity`=1.
- Reset mid-op: drop `rst_n` during SHIFT at `cnt`=4. Outputs go to 0 immediately. After release, a fresh XOR 8'hF0^8'h0F completes with `result`=8'hFF, `parity`=0.
